// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character LCD write driver.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC
  } lcd_state_e;

  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned RS_BIT   = 8;
  localparam int unsigned GO_BIT   = 15;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data[7:1] == CMD_HOME[7:1]));
  endfunction

endpackage

// File: rtl/lcd_hd44780_driver_slot.sv
// One-entry pending command buffer with sticky overflow flag.
module lcd_cmd_slot (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [8:0] push_word,
  input  logic       pop,
  input  logic       clr_ovf,
  output logic [8:0] pend_word,
  output logic       pend_valid,
  output logic       overflow
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_word  <= '0;
      pend_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      // A pop on the same edge frees the slot, so a simultaneous push is accepted.
      if (push && (!pend_valid || pop)) begin
        pend_word  <= push_word;
        pend_valid <= 1'b1;
      end else if (pop) begin
        pend_valid <= 1'b0;
      end

      if (push && pend_valid && !pop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lcd_hd44780_driver.sv
// Turns toggle-launched PIO command words into HD44780 write cycles with
// setup/enable/hold timing and a post-write execution wait.
module lcd_hd44780_driver
  import lcd_pkg::*;
#(
  parameter int unsigned TAS_CYC   = 2,
  parameter int unsigned EN_CYC    = 12,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned SHORT_CYC = 2000,
  parameter int unsigned LONG_CYC  = 82000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cmd_word,
  input  logic        clr_ovf,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        busy,
  output logic [15:0] status_word
);

  localparam int CW = $clog2(LONG_CYC + 1);

  localparam logic [CW-1:0] TAS_LD   = CW'(TAS_CYC - 1);
  localparam logic [CW-1:0] EN_LD    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] SHORT_LD = CW'(SHORT_CYC - 1);
  localparam logic [CW-1:0] LONG_LD  = CW'(LONG_CYC - 1);

  lcd_state_e    state;
  logic [CW-1:0] cnt;
  logic          tog_ref;

  logic       new_cmd;
  logic       exec_end;
  logic       push;
  logic       pop;
  logic [8:0] in_word;
  logic [8:0] pend_word;
  logic       pend_valid;
  logic       overflow;
  logic       unused_bits;

  assign in_word     = {cmd_word[RS_BIT], cmd_word[DATA_LSB +: 8]};
  assign unused_bits = ^cmd_word[14:9];

  assign new_cmd  = cmd_word[GO_BIT] != tog_ref;
  assign exec_end = (state == EXEC) && (cnt == '0);
  // At EXEC end with an empty slot the new word bypasses the slot straight to active.
  assign push     = new_cmd && (state != IDLE) && !(exec_end && !pend_valid);
  assign pop      = exec_end && pend_valid;

  lcd_cmd_slot u_slot (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_word  (in_word),
    .pop        (pop),
    .clr_ovf    (clr_ovf),
    .pend_word  (pend_word),
    .pend_valid (pend_valid),
    .overflow   (overflow)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      tog_ref  <= 1'b0;
      lcd_data <= '0;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
    end else begin
      if (new_cmd) begin
        tog_ref <= cmd_word[GO_BIT];
      end

      unique case (state)
        IDLE: begin
          if (new_cmd) begin
            lcd_rs   <= in_word[8];
            lcd_data <= in_word[7:0];
            cnt      <= TAS_LD;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            lcd_en <= 1'b1;
            cnt    <= EN_LD;
            state  <= PULSE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            lcd_en <= 1'b0;
            cnt    <= HOLD_LD;
            state  <= HOLD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cnt   <= is_long_cmd(lcd_rs, lcd_data) ? LONG_LD : SHORT_LD;
            state <= EXEC;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            if (pend_valid) begin
              lcd_rs   <= pend_word[8];
              lcd_data <= pend_word[7:0];
              cnt      <= TAS_LD;
              state    <= SETUP;
            end else if (new_cmd) begin
              lcd_rs   <= in_word[8];
              lcd_data <= in_word[7:0];
              cnt      <= TAS_LD;
              state    <= SETUP;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign lcd_rw      = 1'b0;
  assign busy        = (state != IDLE) || pend_valid;
  assign status_word = {13'b0, overflow, pend_valid, busy};

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Directed, table-driven bench for the HD44780 write driver (shortened execution waits).
module tb_lcd_hd44780_driver;

  localparam int unsigned TAS   = 2;
  localparam int unsigned EN    = 12;
  localparam int unsigned HOLD  = 1;
  localparam int unsigned SHORT = 50;
  localparam int unsigned LONG  = 300;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cmd_word;
  logic        clr_ovf;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic        busy;
  logic [15:0] status_word;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic tog = 1'b0;

  always #5 clk = ~clk;

  lcd_hd44780_driver #(
    .TAS_CYC   (TAS),
    .EN_CYC    (EN),
    .HOLD_CYC  (HOLD),
    .SHORT_CYC (SHORT),
    .LONG_CYC  (LONG)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_word    (cmd_word),
    .clr_ovf     (clr_ovf),
    .lcd_data    (lcd_data),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_en      (lcd_en),
    .busy        (busy),
    .status_word (status_word)
  );

  typedef struct {
    logic [15:0] base;
    logic        exp_rs;
    logic [7:0]  exp_data;
    logic        exp_long;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic send(input logic rs, input logic [7:0] data);
    @(negedge clk);
    tog = ~tog;
    cmd_word = {tog, 6'b0, rs, data};
  endtask

  // Issues one command and measures en rise/fall and busy drop relative to the capture edge.
  task automatic run_cmd(input logic [15:0] base, input logic ers, input logic [7:0] edata,
                         input logic elong, input string tag);
    int rise = -1;
    int fall = -1;
    int done = -1;
    int pulses = 0;
    logic prev_en = 1'b0;
    int exp_done = int'(TAS + EN + HOLD + (elong ? LONG : SHORT));
    @(negedge clk);
    tog = ~tog;
    cmd_word = {tog, base[14:0]};
    @(posedge clk); #1;
    check({tag, " rs"}, 32'(lcd_rs), 32'(ers));
    check({tag, " data"}, 32'(lcd_data), 32'(edata));
    check({tag, " status"}, 32'(status_word), 32'h0001);
    for (int c = 1; c <= exp_done + 20; c++) begin
      @(posedge clk); #1;
      if (lcd_en && !prev_en) begin
        pulses++;
        if (rise < 0) rise = c;
      end
      if (!lcd_en && prev_en && fall < 0) fall = c;
      prev_en = lcd_en;
      if (!busy) begin
        done = c;
        break;
      end
    end
    check({tag, " en_rise"}, 32'(rise), 32'(TAS));
    check({tag, " en_fall"}, 32'(fall), 32'(TAS + EN));
    check({tag, " busy_drop"}, 32'(done), 32'(exp_done));
    check({tag, " pulses"}, 32'(pulses), 32'd1);
    check({tag, " idle_status"}, 32'(status_word), 32'h0000);
  endtask

  initial begin
    int en_seen;
    int pulses;
    int done;
    logic prev_en;
    logic [7:0] seen[2];
    int e_total;

    vecs[0] = '{16'h0141, 1'b1, 8'h41, 1'b0};
    vecs[1] = '{16'h0001, 1'b0, 8'h01, 1'b1};
    vecs[2] = '{16'h7E02, 1'b0, 8'h02, 1'b1};
    vecs[3] = '{16'h0003, 1'b0, 8'h03, 1'b1};
    vecs[4] = '{16'h0101, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{16'h0004, 1'b0, 8'h04, 1'b0};
    vecs[6] = '{16'h0038, 1'b0, 8'h38, 1'b0};
    vecs[7] = '{16'h4280, 1'b0, 8'h80, 1'b0};

    reset_n  = 1'b0;
    cmd_word = 16'h0000;
    clr_ovf  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset status", 32'(status_word), 32'h0000);
    check("reset data", 32'(lcd_data), 32'h00);
    check("reset rs", 32'(lcd_rs), 32'h0);
    check("reset en", 32'(lcd_en), 32'h0);

    en_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (lcd_en || busy || status_word != 16'h0000) en_seen++;
    end
    check("idle 100 cycles", 32'(en_seen), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i].base, vecs[i].exp_rs, vecs[i].exp_data, vecs[i].exp_long,
              $sformatf("vec%0d", i));
      check("rw low", 32'(lcd_rw), 32'h0);
    end

    // Three rapid toggles: first active, second pending, third dropped (clr_ovf loses to set).
    send(1'b1, 8'h30);
    send(1'b1, 8'h31);
    send(1'b1, 8'h32);
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    check("burst status", 32'(status_word), 32'h0007);
    check("burst active data", 32'(lcd_data), 32'h30);
    @(negedge clk);
    clr_ovf = 1'b0;
    pulses = 0;
    prev_en = 1'b0;
    seen[0] = 8'h00;
    seen[1] = 8'h00;
    for (int c = 0; c < 2 * int'(TAS + EN + HOLD + SHORT) + 20; c++) begin
      @(posedge clk); #1;
      if (lcd_en && !prev_en) begin
        if (pulses < 2) seen[pulses] = lcd_data;
        pulses++;
      end
      prev_en = lcd_en;
      if (!busy) break;
    end
    check("burst pulses", 32'(pulses), 32'd2);
    check("burst first", 32'(seen[0]), 32'h30);
    check("burst second", 32'(seen[1]), 32'h31);
    check("ovf sticky", 32'(status_word), 32'h0004);
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    #1;
    check("ovf cleared", 32'(status_word), 32'h0000);

    // Toggle landing exactly on the EXEC-end edge with an empty slot.
    e_total = int'(TAS + EN + HOLD + SHORT);
    send(1'b1, 8'h41);
    @(posedge clk);
    repeat (e_total - 1) @(posedge clk);
    #1;
    check("pre-end busy", 32'(busy), 32'h1);
    send(1'b0, 8'h38);
    @(posedge clk); #1;
    check("chain data", 32'(lcd_data), 32'h38);
    check("chain rs", 32'(lcd_rs), 32'h0);
    check("chain status", 32'(status_word), 32'h0001);
    done = -1;
    en_seen = -1;
    for (int c = 1; c <= e_total + 20; c++) begin
      @(posedge clk); #1;
      if (lcd_en && en_seen < 0) en_seen = c;
      if (!busy) begin
        done = c;
        break;
      end
    end
    check("chain en_rise", 32'(en_seen), 32'(TAS));
    check("chain busy_drop", 32'(done), 32'(e_total));

    // Asynchronous reset in the middle of the enable pulse.
    send(1'b1, 8'h55);
    @(posedge clk);
    repeat (TAS + 3) @(posedge clk);
    #2;
    check("pre-reset en", 32'(lcd_en), 32'h1);
    reset_n = 1'b0;
    #1;
    check("reset en drop", 32'(lcd_en), 32'h0);
    check("reset status mid", 32'(status_word), 32'h0000);
    check("reset data mid", 32'(lcd_data), 32'h00);
    cmd_word = 16'h0000;
    tog = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post-reset idle", 32'(status_word), 32'h0000);
    run_cmd(16'h0148, 1'b1, 8'h48, 1'b0, "post-reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
